vga_window_scanner: RTL and testbench
=====================================

// Module: vga_window_scanner
// PURPOSE
//  Parametrised VGA timing generator and picture-window scanner. Produces H/V sync and blanking
//  for any mode, and places a PIC_H x PIC_V ROM image at offset (PIC_X,PIC_Y) with 1x/2x/4x
//  pixel replication. Compensates ROM read latency so sync, blank and RGB leave aligned.
//  Sits between the pixel-clock divider and the VGA DAC pins; drives an external image ROM.
// PARAMETERS
//  HA/HF/HS/HB  640/16/96/48  horizontal active/front porch/sync/back porch (pixels); HT=sum
//  VA/VF/VS/VB  480/10/2/33   vertical active/front porch/sync/back porch (lines); VT=sum
//  HS_POL,VS_POL  0,0         active level of hsync/vsync pulse
//  PIC_H,PIC_V  280,210       image size in ROM pixels
//  PIC_X,PIC_Y  0,0           window top-left in screen pixels
//  SCALE_LOG2   0             replication factor 2**SCALE_LOG2 (0..2), both axes
//  ROM_LAT      1             cycles from rom_addr change to matching rom_q (1..4)
//  CW           8             bits per colour channel
//  AW           16            ROM address width
//  BG_COLOR     0             3*CW-bit {R,G,B} for active pixels outside the window
// PORTS
//  clk25        in   1     pixel clock
//  KEY0         in   1     reset, asynchronous, active-low
//  en           in   1     picture enable; sampled only at frame start
//  rom_q        in   3*CW  ROM data {R,G,B}
//  rom_addr     out  AW    ROM address (registered)
//  vga_r/g/b    out  CW    colour channels
//  vga_hs       out  1     horizontal sync (registered)
//  vga_vs       out  1     vertical sync (registered)
//  vga_blank_n  out  1     1 = active display area (registered)
//  vga_sync_n   out  1     constant 1
//  frame_start  out  1     1-cycle pulse, aligned with output of pixel (0,0)
// BEHAVIOUR
//  - One clock (clk25); reset asynchronous, active-low (KEY0).
//  - Reset values: hcnt=vcnt=0, rom_addr=0, vga_hs=~HS_POL, vga_vs=~VS_POL, vga_blank_n=0,
//    RGB=0, frame_start=0, en_frame=0, all delay-pipeline stages cleared. Reset mid-line
//    takes effect immediately, without a clock edge.
//  - Counters: hcnt 0..HT-1, wraps to 0. vcnt increments when hcnt==HT-1 and wraps VT-1 -> 0.
//  - Stage-0 flags for counter (h,v):
//    - active = h<HA && v<VA.
//    - hsync = h in [HA+HF, HA+HF+HS); vsync = v in [VA+VF, VA+VF+VS).
//    - win = en_frame && h in [PIC_X, PIC_X+PIC_H<<S) && v in [PIC_Y, PIC_Y+PIC_V<<S).
//  - en_frame: loads en on the edge where (h,v)==(0,0). Changes of en mid-frame have no effect
//    until the next frame. This is tear-free switching.
//  - Address: rom_addr = ((v-PIC_Y)>>S)*PIC_H + ((h-PIC_X)>>S) when win, registered 1 cycle.
//    Built incrementally from a column sub-counter and a line-base register; no multiplier.
//    - Replicated lines restart at the same line base.
//    - Outside win, rom_addr holds its last value.
//    - Reloads to 0 at (0,0).
//  - Latency: D = 1+ROM_LAT. Flags for counter (h,v) at cycle t are delayed D stages.
//    vga_hs/vs/blank_n and the RGB select for that pixel are valid in cycle t+D, together with
//    rom_q.
//  - RGB (combinational from delayed flags): win_d ? rom_q : active_d ? BG_COLOR : 0.
//  - vga_blank_n = active_d, independent of the window.
//  - frame_start = 1 exactly in cycle t+D for (h,v)=(0,0).
//  - Elaboration error when PIC_X+(PIC_H<<S)>HA, PIC_Y+(PIC_V<<S)>VA, or PIC_H*PIC_V>2**AW.
// TESTING  (small mode unless stated)
//  Mode: HA/HF/HS/HB=16/2/3/3 (HT=24); VA/VF/VS/VB=8/1/2/1 (VT=12); PIC 4x3 at (2,1);
//  ROM_LAT=1, so D=2. ROM model returns rom_q = {addr} after 1 cycle.
//  1. KEY0 low -> rom_addr=0, hs=vs=1, blank_n=0, RGB=0. Release -> vga_hs low for 3 cycles
//     starting 2 cycles after hcnt=18; vga_vs low for lines 9-10.
//  2. Scan -> rom_addr 0..3 for v=1 h=2..5, 4..7 on v=2, 8..11 on v=3. Next frame restarts at 0.
//  3. Alignment -> RGB equals the address issued D cycles earlier inside the window;
//     BG_COLOR elsewhere in the active area; 0 during blanking. frame_start pulses once per
//     288 cycles.
//  4. SCALE_LOG2=1 -> rom_addr 0,0,1,1,2,2,3,3 on lines v=1 and v=2; 4,4,5,5.. on v=3 and v=4.
//  5. en=1 -> 0 mid-frame: picture completes the current frame; the next frame is all
//     BG_COLOR. en back to 1 mid-frame -> picture returns from the following frame only.
//  6. KEY0 pulsed low at h=10,v=4: outputs take reset values asynchronously. After release the
//     scan restarts from (0,0) and test 2 sequence repeats.

Source files
------------

// File: rtl/vga_window_scanner_if.sv
// Pixel-side bus of the window scanner: picture enable, image ROM port and VGA DAC pins.
interface vga_window_scanner_if #(
  parameter int unsigned CW = 8,
  parameter int unsigned AW = 16
);
  logic            en;
  logic [3*CW-1:0] rom_q;
  logic [AW-1:0]   rom_addr;
  logic [CW-1:0]   vga_r;
  logic [CW-1:0]   vga_g;
  logic [CW-1:0]   vga_b;
  logic            vga_hs;
  logic            vga_vs;
  logic            vga_blank_n;
  logic            vga_sync_n;
  logic            frame_start;

  modport master (
    input  en, rom_q,
    output rom_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start
  );

  modport slave (
    output en, rom_q,
    input  rom_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start
  );
endinterface

// File: rtl/vga_window_scanner.sv
// VGA timing generator with a replicated ROM picture window; flags are delayed to line up with ROM data.
module vga_window_scanner #(
  parameter int unsigned     HA         = 640,
  parameter int unsigned     HF         = 16,
  parameter int unsigned     HS         = 96,
  parameter int unsigned     HB         = 48,
  parameter int unsigned     VA         = 480,
  parameter int unsigned     VF         = 10,
  parameter int unsigned     VS         = 2,
  parameter int unsigned     VB         = 33,
  parameter bit              HS_POL     = 1'b0,
  parameter bit              VS_POL     = 1'b0,
  parameter int unsigned     PIC_H      = 280,
  parameter int unsigned     PIC_V      = 210,
  parameter int unsigned     PIC_X      = 0,
  parameter int unsigned     PIC_Y      = 0,
  parameter int unsigned     SCALE_LOG2 = 0,
  parameter int unsigned     ROM_LAT    = 1,
  parameter int unsigned     CW         = 8,
  parameter int unsigned     AW         = 16,
  parameter logic [3*CW-1:0] BG_COLOR   = '0
) (
  input logic            clk25,
  input logic            KEY0,
  vga_window_scanner_if.master bus
);
  localparam int unsigned HT       = HA + HF + HS + HB;
  localparam int unsigned VT       = VA + VF + VS + VB;
  localparam int unsigned HW       = $clog2(HT);
  localparam int unsigned VW       = $clog2(VT);
  localparam int unsigned REP      = 1 << SCALE_LOG2;
  localparam int unsigned WIN_W    = PIC_H << SCALE_LOG2;
  localparam int unsigned WIN_H    = PIC_V << SCALE_LOG2;
  localparam int unsigned D        = 1 + ROM_LAT;
  localparam int unsigned HS_START = HA + HF;
  localparam int unsigned VS_START = VA + VF;

  // Reject windows that do not fit the active area or the ROM address space
  if (PIC_X + WIN_W > HA) begin : g_bad_x
    $error("picture window exceeds active width");
  end
  if (PIC_Y + WIN_H > VA) begin : g_bad_y
    $error("picture window exceeds active height");
  end
  if (64'(PIC_H) * 64'(PIC_V) > (64'd1 << AW)) begin : g_bad_aw
    $error("picture does not fit the ROM address width");
  end
  if (SCALE_LOG2 > 2) begin : g_bad_scale
    $error("SCALE_LOG2 must be 0..2");
  end
  if (ROM_LAT < 1 || ROM_LAT > 4) begin : g_bad_lat
    $error("ROM_LAT must be 1..4");
  end

  logic [HW-1:0]   hcnt;
  logic [VW-1:0]   vcnt;
  logic [31:0]     hx, vx, hrel, vrel;
  logic            h_last, at_origin;
  logic            en_frame, en_cur_c;
  logic            active_c, hsync_c, vsync_c, win_c;
  logic [D-1:0]    act_p, win_p, fs_p, hs_p, vs_p;
  logic [AW-1:0]   rom_addr_r, line_base, lb_cur;
  logic [1:0]      hsub, vsub, vs_cur;
  logic [3*CW-1:0] rgb_c;

  assign hx        = 32'(hcnt);
  assign vx        = 32'(vcnt);
  assign hrel      = hx - PIC_X;
  assign vrel      = vx - PIC_Y;
  assign h_last    = (hx == HT - 1);
  assign at_origin = (hcnt == '0) && (vcnt == '0);

  // Stage-0 flags; the enable seen at (0,0) governs the whole frame, including pixel (0,0)
  always_comb begin
    en_cur_c = at_origin ? bus.en : en_frame;
    active_c = (hx < HA) && (vx < VA);
    hsync_c  = (hx - HS_START) < HS;
    vsync_c  = (vx - VS_START) < VS;
    win_c    = en_cur_c && (hrel < WIN_W) && (vrel < WIN_H);
    lb_cur   = at_origin ? '0 : line_base;
    vs_cur   = at_origin ? '0 : vsub;
  end

  // Pixel and line counters, frame-latched picture enable
  always_ff @(posedge clk25 or negedge KEY0) begin
    if (!KEY0) begin
      hcnt     <= '0;
      vcnt     <= '0;
      en_frame <= 1'b0;
    end else begin
      if (at_origin) en_frame <= bus.en;
      if (h_last) begin
        hcnt <= '0;
        vcnt <= (vx == VT - 1) ? '0 : vcnt + VW'(1);
      end else begin
        hcnt <= hcnt + HW'(1);
      end
    end
  end

  // ROM address: column replication counter within a line, restarting from the line base
  always_ff @(posedge clk25 or negedge KEY0) begin
    if (!KEY0) begin
      rom_addr_r <= '0;
      hsub       <= '0;
    end else if (win_c) begin
      if (hrel == 0) begin
        rom_addr_r <= lb_cur;
        hsub       <= '0;
      end else if (hsub == 2'(REP - 1)) begin
        rom_addr_r <= rom_addr_r + AW'(1);
        hsub       <= '0;
      end else begin
        hsub <= hsub + 2'd1;
      end
    end else if (at_origin) begin
      rom_addr_r <= '0;
      hsub       <= '0;
    end
  end

  // Line base advances by one ROM row after every REP window lines
  always_ff @(posedge clk25 or negedge KEY0) begin
    if (!KEY0) begin
      line_base <= '0;
      vsub      <= '0;
    end else if (win_c && (hrel == WIN_W - 1)) begin
      if (vs_cur == 2'(REP - 1)) begin
        line_base <= lb_cur + AW'(PIC_H);
        vsub      <= '0;
      end else begin
        line_base <= lb_cur;
        vsub      <= vs_cur + 2'd1;
      end
    end else if (at_origin) begin
      line_base <= '0;
      vsub      <= '0;
    end
  end

  // Delay flags by D cycles so sync/blank/select meet the ROM data
  always_ff @(posedge clk25 or negedge KEY0) begin
    if (!KEY0) begin
      act_p <= '0;
      win_p <= '0;
      fs_p  <= '0;
      hs_p  <= {D{~HS_POL}};
      vs_p  <= {D{~VS_POL}};
    end else begin
      act_p <= {act_p[D-2:0], active_c};
      win_p <= {win_p[D-2:0], win_c};
      fs_p  <= {fs_p[D-2:0], at_origin};
      hs_p  <= {hs_p[D-2:0], hsync_c ? HS_POL : ~HS_POL};
      vs_p  <= {vs_p[D-2:0], vsync_c ? VS_POL : ~VS_POL};
    end
  end

  // Colour select from delayed flags
  always_comb begin
    rgb_c = '0;
    if (win_p[D-1])      rgb_c = bus.rom_q;
    else if (act_p[D-1]) rgb_c = BG_COLOR;
  end

  assign bus.rom_addr    = rom_addr_r;
  assign bus.vga_r       = rgb_c[3*CW-1 -: CW];
  assign bus.vga_g       = rgb_c[2*CW-1 -: CW];
  assign bus.vga_b       = rgb_c[CW-1:0];
  assign bus.vga_hs      = hs_p[D-1];
  assign bus.vga_vs      = vs_p[D-1];
  assign bus.vga_blank_n = act_p[D-1];
  assign bus.vga_sync_n  = 1'b1;
  assign bus.frame_start = fs_p[D-1];
endmodule

// File: tb/tb_vga_window_scanner.sv
// Directed bench for the window scanner in a small 24x12 mode, 1x and 2x replication.
module tb_vga_window_scanner;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 1;
  localparam int HT = 24, VT = 12, FT = 288;
  localparam int PW = 4, PV = 3, PX = 2, PY = 1;
  localparam logic [23:0] BG = 24'hA5C3E1;
  localparam int HIST = 600;

  logic clk25 = 1'b0;
  logic KEY0  = 1'b0;
  always #5 clk25 = ~clk25;

  vga_window_scanner_if #(.CW(8), .AW(16)) b0 ();
  vga_window_scanner_if #(.CW(8), .AW(16)) b1 ();

  vga_window_scanner #(
    .HA(HA), .HF(HF), .HS(HS), .HB(HB), .VA(VA), .VF(VF), .VS(VS), .VB(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIC_H(PW), .PIC_V(PV), .PIC_X(PX), .PIC_Y(PY),
    .SCALE_LOG2(0), .ROM_LAT(1), .CW(8), .AW(16), .BG_COLOR(BG)
  ) dut0 (.clk25(clk25), .KEY0(KEY0), .bus(b0.master));

  vga_window_scanner #(
    .HA(HA), .HF(HF), .HS(HS), .HB(HB), .VA(VA), .VF(VF), .VS(VS), .VB(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIC_H(PW), .PIC_V(PV), .PIC_X(PX), .PIC_Y(PY),
    .SCALE_LOG2(1), .ROM_LAT(1), .CW(8), .AW(16), .BG_COLOR(BG)
  ) dut1 (.clk25(clk25), .KEY0(KEY0), .bus(b1.master));

  // ROM models: data equals address, one cycle of latency
  always @(posedge clk25) begin
    b0.rom_q <= 24'(b0.rom_addr);
    b1.rom_q <= 24'(b1.rom_addr);
  end

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;
  int exp_a0   = 0;
  int exp_a1   = 0;
  bit fen [16];
  logic [15:0] ha0 [HIST];
  logic [15:0] ha1 [HIST];
  logic        hs0 [HIST];
  logic        vs0 [HIST];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s k=%0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  function automatic bit in_win(input int p, input int s);
    int h, v;
    h = p % HT;
    v = (p / HT) % VT;
    return fen[(p / FT) % 16] && h >= PX && h < PX + (PW << s) && v >= PY && v < PY + (PV << s);
  endfunction

  function automatic int addr_of(input int p, input int s);
    return (((p / HT) % VT - PY) >> s) * PW + ((p % HT - PX) >> s);
  endfunction

  task automatic chk_scan(input string nm, input int s, input int ea, input logic [15:0] a,
                          input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                          input logic hs, input logic vs, input logic bn, input logic fs);
    int p, h, v;
    logic ehs, evs, ebn, efs;
    logic [23:0] ergb;
    p = k - 2;
    if (p < 0) begin
      ehs = 1'b1; evs = 1'b1; ebn = 1'b0; efs = 1'b0; ergb = '0;
    end else begin
      h    = p % HT;
      v    = (p / HT) % VT;
      ehs  = !(h >= HA + HF && h < HA + HF + HS);
      evs  = !(v >= VA + VF && v < VA + VF + VS);
      ebn  = (h < HA) && (v < VA);
      efs  = (p % FT) == 0;
      ergb = in_win(p, s) ? 24'(addr_of(p, s)) : (ebn ? BG : 24'h0);
    end
    chk({nm, ".addr"},  32'(a),         32'(ea));
    chk({nm, ".hs"},    32'(hs),        32'(ehs));
    chk({nm, ".vs"},    32'(vs),        32'(evs));
    chk({nm, ".blank"}, 32'(bn),        32'(ebn));
    chk({nm, ".fs"},    32'(fs),        32'(efs));
    chk({nm, ".rgb"},   32'({r, g, b}), 32'(ergb));
  endtask

  task automatic chk_reset(input string nm, input logic [15:0] a, input logic [7:0] r,
                           input logic [7:0] g, input logic [7:0] b, input logic hs,
                           input logic vs, input logic bn, input logic sn, input logic fs);
    chk({nm, ".rst_addr"},  32'(a),         32'h0);
    chk({nm, ".rst_hs"},    32'(hs),        32'h1);
    chk({nm, ".rst_vs"},    32'(vs),        32'h1);
    chk({nm, ".rst_blank"}, 32'(bn),        32'h0);
    chk({nm, ".rst_rgb"},   32'({r, g, b}), 32'h0);
    chk({nm, ".rst_fs"},    32'(fs),        32'h0);
    chk({nm, ".sync_n"},    32'(sn),        32'h1);
  endtask

  task automatic reset_both();
    chk_reset("d0", b0.rom_addr, b0.vga_r, b0.vga_g, b0.vga_b, b0.vga_hs, b0.vga_vs,
              b0.vga_blank_n, b0.vga_sync_n, b0.frame_start);
    chk_reset("d1", b1.rom_addr, b1.vga_r, b1.vga_g, b1.vga_b, b1.vga_hs, b1.vga_vs,
              b1.vga_blank_n, b1.vga_sync_n, b1.frame_start);
  endtask

  // One clock: record the frame enable at (0,0), advance, then check both scanners
  task automatic step();
    if (k % FT == 0) fen[(k / FT) % 16] = b0.en;
    @(posedge clk25);
    @(negedge clk25);
    k++;
    if (in_win(k - 1, 0)) exp_a0 = addr_of(k - 1, 0);
    else if ((k - 1) % FT == 0) exp_a0 = 0;
    if (in_win(k - 1, 1)) exp_a1 = addr_of(k - 1, 1);
    else if ((k - 1) % FT == 0) exp_a1 = 0;
    if (k < HIST) begin
      ha0[k] = b0.rom_addr;
      ha1[k] = b1.rom_addr;
      hs0[k] = b0.vga_hs;
      vs0[k] = b0.vga_vs;
    end
    chk_scan("d0", 0, exp_a0, b0.rom_addr, b0.vga_r, b0.vga_g, b0.vga_b,
             b0.vga_hs, b0.vga_vs, b0.vga_blank_n, b0.frame_start);
    chk_scan("d1", 1, exp_a1, b1.rom_addr, b1.vga_r, b1.vga_g, b1.vga_b,
             b1.vga_hs, b1.vga_vs, b1.vga_blank_n, b1.frame_start);
  endtask

  task automatic run_to(input int kk);
    while (k < kk) step();
  endtask

  // Hand-computed address and sync sequences of the first frame and a half
  task automatic chk_lines();
    int t0 [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
    int t1 [8]  = '{0, 0, 1, 1, 2, 2, 3, 3};
    int hs_exp [5] = '{1, 0, 0, 0, 1};
    for (int i = 0; i < 4; i++) begin
      chk("t2.v1",   32'(ha0[27 + i]),  32'(t0[i]));
      chk("t2.v2",   32'(ha0[51 + i]),  32'(t0[4 + i]));
      chk("t2.v3",   32'(ha0[75 + i]),  32'(t0[8 + i]));
      chk("t2.f1v1", 32'(ha0[315 + i]), 32'(t0[i]));
    end
    for (int i = 0; i < 8; i++) begin
      chk("t4.v1", 32'(ha1[27 + i]), 32'(t1[i]));
      chk("t4.v2", 32'(ha1[51 + i]), 32'(t1[i]));
      chk("t4.v3", 32'(ha1[75 + i]), 32'(t1[i] + 4));
      chk("t4.v4", 32'(ha1[99 + i]), 32'(t1[i] + 4));
    end
    for (int i = 0; i < 5; i++) chk("t1.hs", 32'(hs0[19 + i]), 32'(hs_exp[i]));
    chk("t1.vs217", 32'(vs0[217]), 32'h1);
    chk("t1.vs218", 32'(vs0[218]), 32'h0);
    chk("t1.vs265", 32'(vs0[265]), 32'h0);
    chk("t1.vs266", 32'(vs0[266]), 32'h1);
  endtask

  task automatic set_en(input logic v);
    b0.en = v;
    b1.en = v;
  endtask

  initial begin
    set_en(1'b1);
    // Test 1: reset values while KEY0 is held low
    repeat (3) @(negedge clk25);
    reset_both();
    KEY0 = 1'b1;
    k = 0;

    // Tests 2-4: first frame and start of the next
    run_to(300);
    // Test 5: drop enable early in frame 1; frame 1 keeps the picture
    set_en(1'b0);
    run_to(340);
    chk("t5.f1pic", 32'({b0.vga_r, b0.vga_g, b0.vga_b}), 32'h4);
    run_to(350);
    chk_lines();
    run_to(600);
    // Re-enable early in frame 2; frame 2 stays background, frame 3 shows the picture
    set_en(1'b1);
    run_to(604);
    chk("t5.f2bg", 32'({b0.vga_r, b0.vga_g, b0.vga_b}), 32'(BG));
    run_to(893);
    chk("t5.f3pic", 32'({b0.vga_r, b0.vga_g, b0.vga_b}), 32'h1);

    // Test 6: asynchronous reset at h=10, v=4 of frame 4
    run_to(4 * FT + 4 * HT + 10);
    #2 KEY0 = 1'b0;
    #1 reset_both();
    @(negedge clk25);
    reset_both();
    KEY0 = 1'b1;
    k = 0;
    exp_a0 = 0;
    exp_a1 = 0;
    for (int i = 0; i < 16; i++) fen[i] = 1'b0;
    run_to(350);
    chk_lines();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
